cpu_c1_master: RTL and testbench

- CPU-side bus master that sits directly upstream of the cache and drives its CPU bus (A1/D1/C1).
- Turns a simple single-cycle host request (command, full address, 32-bit write data) into the cache's two-beat command/address protocol, releases the bus, waits for C1_RESPONSE, collects read data, and returns one response pulse to the host.
- Replaces hand-written bus sequencing in benches and CPU models.

---
 rtl/cpu_c1_master_if.sv | 25 ++
 rtl/cpu_c1_master.sv | 184 ++++++++++++++++++
 tb/tb_cpu_c1_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_c1_master_if.sv
// Host-side request/response handshake of the C1 bus master.
// master = host driving requests, slave = bus master accepting them.
interface cpu_c1_master_if #(
  parameter int CACHE_ADDR_SIZE = 19,
  parameter int CTR1_BUS_SIZE   = 3
);
  logic                       req_valid;
  logic                       req_ready;
  logic [CTR1_BUS_SIZE-1:0]   req_cmd;
  logic [CACHE_ADDR_SIZE-1:0] req_addr;
  logic [31:0]                req_wdata;
  logic                       rsp_valid;
  logic                       rsp_err;
  logic [31:0]                rsp_rdata;

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/cpu_c1_master.sv
// CPU-side master for the cache A1/D1/C1 bus.
// Two-beat cmd/addr issue, response wait with timeout, host completion.
module cpu_c1_master #(
  parameter int CACHE_ADDR_SIZE   = 19,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int ADDR1_BUS_SIZE    = 15,
  parameter int DATA_BUS_SIZE     = 16,
  parameter int CTR1_BUS_SIZE     = 3,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                      CLK,
  input  logic                      RESET,
  cpu_c1_master_if.slave            host,
  inout  wire [ADDR1_BUS_SIZE-1:0]  A1,
  inout  wire [DATA_BUS_SIZE-1:0]   D1,
  inout  wire [CTR1_BUS_SIZE-1:0]   C1
);

  localparam int CW = CTR1_BUS_SIZE;
  localparam logic [CW-1:0] NOP     = CW'(0);
  localparam logic [CW-1:0] READ8   = CW'(1);
  localparam logic [CW-1:0] READ16  = CW'(2);
  localparam logic [CW-1:0] READ32  = CW'(3);
  localparam logic [CW-1:0] WRITE8  = CW'(5);
  localparam logic [CW-1:0] WRITE16 = CW'(6);
  localparam logic [CW-1:0] WRITE32 = CW'(7);
  localparam logic [CW-1:0] C1_RSP  = CW'(7);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, BEAT1, BEAT2, WAIT_RSP, RX_HI, TURN
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]              cmd_q, cmd_d;
  logic [CACHE_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [DATA_BUS_SIZE-1:0]   lo_q, lo_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       vld_q, vld_d;
  logic                       err_q, err_d;

  logic                       is_wr;
  logic                       rsp_seen;
  logic                       a_oe, d_oe;
  logic [ADDR1_BUS_SIZE-1:0]  a_val;
  logic [DATA_BUS_SIZE-1:0]   d_val;

  assign is_wr    = (cmd_q == WRITE8) || (cmd_q == WRITE16)
                 || (cmd_q == WRITE32);
  // Only a clean 1-pattern counts; x/z on a floating bus does not.
  assign rsp_seen = (C1 === C1_RSP);

  assign host.req_ready = (state_q == IDLE);
  assign host.rsp_valid = vld_q;
  assign host.rsp_err   = err_q;
  assign host.rsp_rdata = rdata_q;

  assign A1 = a_oe ? a_val : 'z;
  assign C1 = a_oe ? cmd_q : 'z;
  assign D1 = d_oe ? d_val : 'z;

  // Bus drive: the master owns A1/C1 (and D1 for writes) only in the beats.
  always_comb begin
    a_oe  = 1'b0;
    d_oe  = 1'b0;
    a_val = '0;
    d_val = '0;
    unique case (state_q)
      BEAT1: begin
        a_oe  = 1'b1;
        a_val = addr_q[CACHE_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
        if (is_wr) begin
          d_oe = 1'b1;
          if (cmd_q == WRITE8)
            d_val = DATA_BUS_SIZE'(wdata_q[7:0]);
          else
            d_val = wdata_q[DATA_BUS_SIZE-1:0];
        end
      end
      BEAT2: begin
        a_oe  = 1'b1;
        a_val = ADDR1_BUS_SIZE'(addr_q[CACHE_OFFSET_SIZE-1:0]);
        if (cmd_q == WRITE32) begin
          d_oe  = 1'b1;
          d_val = wdata_q[31:DATA_BUS_SIZE];
        end
      end
      default: ;
    endcase
  end

  // Next state, request latching, response capture and completion pulse.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (host.req_valid) begin
          if (host.req_cmd == NOP) begin
            vld_d = 1'b1;
            err_d = 1'b1;
          end else begin
            cmd_d   = host.req_cmd;
            addr_d  = host.req_addr;
            wdata_d = host.req_wdata;
            state_d = BEAT1;
          end
        end
      end
      BEAT1: state_d = BEAT2;
      BEAT2: begin
        cnt_d   = '0;
        state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (rsp_seen) begin
          if (cmd_q == READ32) begin
            lo_d    = D1;
            state_d = RX_HI;
          end else begin
            if (cmd_q == READ8)
              rdata_d = 32'(D1[7:0]);
            else if (cmd_q == READ16)
              rdata_d = 32'(D1);
            vld_d   = 1'b1;
            state_d = TURN;
          end
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          vld_d   = 1'b1;
          err_d   = 1'b1;
          state_d = TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_HI: begin
        rdata_d = 32'({D1, lo_q});
        vld_d   = 1'b1;
        state_d = TURN;
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transfer silently.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cpu_c1_master.sv
// Bench for cpu_c1_master: cache responder model plus
// response scoreboard checked on every rsp_valid pulse.
module tb_cpu_c1_master;

  localparam int TO = 8;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  wire [14:0] A1;
  wire [15:0] D1;
  wire [2:0]  C1;

  logic        cache_oe = 1'b0;
  logic [2:0]  c1_drv = 3'd7;
  logic [15:0] d1_drv = '0;

  assign C1 = cache_oe ? c1_drv : 'z;
  assign D1 = cache_oe ? d1_drv : 'z;

  cpu_c1_master_if #(
    .CACHE_ADDR_SIZE(19),
    .CTR1_BUS_SIZE(3)
  ) hif ();

  cpu_c1_master #(
    .CACHE_ADDR_SIZE(19),
    .CACHE_OFFSET_SIZE(4),
    .ADDR1_BUS_SIZE(15),
    .DATA_BUS_SIZE(16),
    .CTR1_BUS_SIZE(3),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .host(hif.slave),
    .A1(A1),
    .D1(D1),
    .C1(C1)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  logic [31:0] model_rd = '0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // A released bus floats (z) or reads 0 in a two-state simulator.
  function automatic logic rel_a();
    return (A1 === '0) || $isunknown(A1);
  endfunction
  function automatic logic rel_d();
    return (D1 === '0) || $isunknown(D1);
  endfunction
  function automatic logic rel_c();
    return (C1 === '0) || $isunknown(C1);
  endfunction
  function automatic logic rel_all();
    return rel_a() && rel_d() && rel_c();
  endfunction

  always @(negedge CLK) begin
    if (hif.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp", 32'd1, 32'd0);
      end else begin
        me = sb.pop_front();
        chk("rsp_err", 32'(hif.rsp_err), 32'(me.err));
        chk("rsp_rdata", hif.rsp_rdata, me.rd);
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!hif.req_ready && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk("req_ready", 32'(hif.req_ready), 32'd1);
  endtask

  task automatic run(input logic [2:0]  cmd,
                     input logic [18:0] addr,
                     input logic [31:0] wd,
                     input int          nw,
                     input logic [15:0] lo,
                     input logic [15:0] hi,
                     input bit          resp);
    exp_t e;
    int   lat;
    int   exp_l;
    logic wr;
    wr = (cmd >= 3'd5);
    if (cmd == 3'd0) begin
      e.err = 1'b1;
      e.rd  = model_rd;
      exp_l = 1;
    end else if (!resp) begin
      e.err = 1'b1;
      e.rd  = '0;
      exp_l = 3 + TO;
    end else begin
      e.err = 1'b0;
      exp_l = 4 + nw;
      case (cmd)
        3'd1: e.rd = {24'h0, lo[7:0]};
        3'd2: e.rd = {16'h0, lo};
        3'd3: begin
          e.rd  = {hi, lo};
          exp_l = 5 + nw;
        end
        default: e.rd = model_rd;
      endcase
    end
    model_rd = e.rd;
    sb.push_back(e);
    wait_ready();
    hif.req_valid = 1'b1;
    hif.req_cmd   = cmd;
    hif.req_addr  = addr;
    hif.req_wdata = wd;
    @(negedge CLK);
    hif.req_valid = 1'b0;
    lat = 1;
    if (cmd == 3'd0) begin
      chk("nop_bus", 32'(rel_all()), 32'd1);
    end else begin
      chk("b1_c1", 32'(C1), 32'(cmd));
      chk("b1_a1", 32'(A1), 32'(addr[18:4]));
      chk("busy_rdy", 32'(hif.req_ready), 32'd0);
      if (wr)
        chk("b1_d1", 32'(D1),
            cmd == 3'd5 ? {24'h0, wd[7:0]} : {16'h0, wd[15:0]});
      else
        chk("b1_d1_rel", 32'(rel_d()), 32'd1);
      // A request while busy must be ignored.
      hif.req_valid = 1'b1;
      hif.req_cmd   = 3'd1;
      @(negedge CLK);
      hif.req_valid = 1'b0;
      lat = 2;
      chk("b2_c1", 32'(C1), 32'(cmd));
      chk("b2_a1", 32'(A1), 32'(addr[3:0]));
      if (cmd == 3'd7)
        chk("b2_d1", 32'(D1), {16'h0, wd[31:16]});
      else
        chk("b2_d1_rel", 32'(rel_d()), 32'd1);
      @(negedge CLK);
      lat = 3;
      chk("wait_rel", 32'(rel_all()), 32'd1);
    end
    while (!hif.rsp_valid && lat < 60) begin
      cache_oe = resp && (lat == 3 + nw ||
                 (cmd == 3'd3 && lat == 4 + nw));
      c1_drv   = 3'd7;
      d1_drv   = (lat == 3 + nw) ? lo : hi;
      @(negedge CLK);
      lat++;
    end
    cache_oe = 1'b0;
    chk("latency", 32'(lat), 32'(exp_l));
    @(negedge CLK);
    chk("one_pulse", 32'(hif.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    hif.req_valid = 1'b0;
    hif.req_cmd   = '0;
    hif.req_addr  = '0;
    hif.req_wdata = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(hif.req_ready), 32'd1);
    chk("rst_valid", 32'(hif.rsp_valid), 32'd0);
    chk("rst_err", 32'(hif.rsp_err), 32'd0);
    chk("rst_rdata", hif.rsp_rdata, 32'd0);
    chk("rst_bus", 32'(rel_all()), 32'd1);
    RESET = 1'b0;
    @(negedge CLK);

    run(3'd7, 19'd547, 32'h0025_C87C, 2, 16'h0, 16'h0, 1'b1);
    run(3'd7, 19'd547, 32'h0025_C87C, 0, 16'h0, 16'h0, 1'b1);
    run(3'd7, 19'd547, 32'h0025_C87C, 0, 16'h0, 16'h0, 1'b1);
    run(3'd3, 19'd547, 32'hDEAD_BEEF, 1, 16'h1234, 16'hABCD, 1'b1);
    run(3'd1, 19'd547, 32'hDEAD_BEEF, 0, 16'h55AA, 16'h0, 1'b1);
    run(3'd2, 19'h1_2345, 32'hDEAD_BEEF, 3, 16'hBEEF, 16'h0, 1'b1);
    run(3'd4, 19'd547, 32'hDEAD_BEEF, 0, 16'h0, 16'h0, 1'b1);
    run(3'd5, 19'h7_FFFF, 32'h1234_5678, 1, 16'h0, 16'h0, 1'b1);
    run(3'd6, 19'h0_0010, 32'h1234_5678, 0, 16'h0, 16'h0, 1'b1);
    run(3'd2, 19'd547, 32'hDEAD_BEEF, 0, 16'h0, 16'h0, 1'b0);
    run(3'd0, 19'd547, 32'hDEAD_BEEF, 0, 16'h0, 16'h0, 1'b1);
    run(3'd3, 19'd99, 32'hDEAD_BEEF, 0, 16'hCAFE, 16'hF00D, 1'b1);

    // Reset in the middle of BEAT2 abandons the transfer.
    wait_ready();
    hif.req_valid = 1'b1;
    hif.req_cmd   = 3'd7;
    hif.req_addr  = 19'd547;
    hif.req_wdata = 32'h0025_C87C;
    @(negedge CLK);
    hif.req_valid = 1'b0;
    @(negedge CLK);
    chk("mid_b2_c1", 32'(C1), 32'd7);
    RESET = 1'b1;
    #1;
    chk("mid_rst_bus", 32'(rel_all()), 32'd1);
    chk("mid_rst_rdy", 32'(hif.req_ready), 32'd1);
    chk("mid_rst_rd", hif.rsp_rdata, 32'd0);
    model_rd = '0;
    repeat (3) @(negedge CLK);
    chk("mid_rst_vld", 32'(hif.rsp_valid), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    run(3'd7, 19'd547, 32'h0025_C87C, 1, 16'h0, 16'h0, 1'b1);
    run(3'd1, 19'd547, 32'hDEAD_BEEF, 0, 16'h0081, 16'h0, 1'b1);

    repeat (4) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
